// File: rtl/plp_uart_tx_fifo.sv
// UART transmit back end: byte FIFO fed by the bus write strobe, drained by an
// 8N1 LSB-first serialiser driving the tx pin.
module plp_uart_tx_fifo #(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned AW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [7:0]    wdata,
    input  logic          clr_ovf,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          ovf,
    output logic          tx
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned BCW   = $clog2(BAUD_DIV);
    localparam logic [BCW-1:0] BC_TOP  = BCW'(BAUD_DIV - 1);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_q, state_d;
    logic [BCW-1:0] bc_q, bc_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     sr_q, sr_d;
    logic [AW-1:0]  rptr_q, wptr_q;
    logic [AW:0]    cnt_d;
    logic           ovf_d;
    logic           tx_d;
    logic           tick;
    logic           pop;
    logic           push;
    logic [7:0]     head;
    logic [7:0]     mem [DEPTH];

    assign tick = (bc_q == '0);
    assign head = mem[rptr_q];
    // A full FIFO still accepts a byte when the serialiser frees a slot this cycle.
    assign push = wr && (!full || pop);

    // Next-state, dequeue and serial line value.
    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        if (state_q != IDLE) begin
            bc_d = tick ? BC_TOP : bc_q - BCW'(1);
        end
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sr_d    = head;
                    bc_d    = BC_TOP;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (tick) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = sr_q[0];
                if (tick) begin
                    sr_d  = {1'b0, sr_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        sr_d    = head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy and sticky overflow; a dropped write beats a simultaneous clear.
    always_comb begin
        cnt_d = count;
        unique case ({push, pop})
            2'b10:   cnt_d = count + (AW + 1)'(1);
            2'b01:   cnt_d = count - (AW + 1)'(1);
            default: cnt_d = count;
        endcase
        ovf_d = ovf;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (wr && !push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bc_q    <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            count   <= cnt_d;
            full    <= (cnt_d == DEPTH_C);
            empty   <= (cnt_d == '0);
            busy    <= (state_d != IDLE);
            ovf     <= ovf_d;
            tx      <= tx_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_plp_uart_tx_fifo.sv
// Scoreboard bench for plp_uart_tx_fifo: a small-divider instance for the FIFO
// and framing cases plus a default-parameter instance for real bit timing.
module tb_plp_uart_tx_fifo;

    localparam int unsigned BD_A = 4;
    localparam int unsigned AW_A = 2;
    localparam int unsigned BD_B = 434;
    localparam int unsigned AW_B = 4;

    logic clk = 1'b0;
    logic rst;
    logic wr_a, clr_a, wr_b, clr_b;
    logic [7:0] wd_a, wd_b;
    logic full_a, empty_a, busy_a, ovf_a, tx_a;
    logic full_b, empty_b, busy_b, ovf_b, tx_b;
    logic [AW_A:0] count_a;
    logic [AW_B:0] count_b;

    always #5 clk = ~clk;

    plp_uart_tx_fifo #(.BAUD_DIV(BD_A), .AW(AW_A)) dut_a (
        .clk(clk), .rst(rst), .wr(wr_a), .wdata(wd_a), .clr_ovf(clr_a),
        .full(full_a), .empty(empty_a), .count(count_a), .busy(busy_a),
        .ovf(ovf_a), .tx(tx_a)
    );

    plp_uart_tx_fifo #(.BAUD_DIV(BD_B), .AW(AW_B)) dut_b (
        .clk(clk), .rst(rst), .wr(wr_b), .wdata(wd_b), .clr_ovf(clr_b),
        .full(full_b), .empty(empty_b), .count(count_b), .busy(busy_b),
        .ovf(ovf_b), .tx(tx_b)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int aborted = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int starts_a[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic line(input int w);
        return (w == 0) ? tx_a : tx_b;
    endfunction

    // Receiver: on each start bit pop the expected byte and check every cycle of the frame.
    task automatic monitor(input int w, input int bd);
        logic       prev;
        logic       have;
        logic       ab;
        logic       lvl;
        logic [7:0] e;
        logic [7:0] got;
        int         bad;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b1;
                continue;
            end
            if (prev && !line(w)) begin
                if (w == 0) starts_a.push_back(cyc);
                e = 8'h00;
                if (w == 0) begin
                    have = (exp_a.size() > 0);
                    if (have) e = exp_a.pop_front();
                end else begin
                    have = (exp_b.size() > 0);
                    if (have) e = exp_b.pop_front();
                end
                if (!have) chk("frame_expected", int'(have), 1);
                bad = 0;
                got = 8'h00;
                ab  = 1'b0;
                for (int k = 0; k < 10 * bd; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst) begin
                        ab = 1'b1;
                        break;
                    end
                    lvl = (k < bd) ? 1'b0 : (k < 9 * bd) ? e[k / bd - 1] : 1'b1;
                    if (line(w) !== lvl) bad++;
                    if (k >= bd && k < 9 * bd && (k % bd) == bd / 2) got[k / bd - 1] = line(w);
                end
                if (ab) aborted++;
                else if (have) begin
                    chk($sformatf("frame_data%0d", w), int'(got), int'(e));
                    chk($sformatf("frame_shape%0d", w), bad, 0);
                end
                prev = ab ? 1'b1 : line(w);
            end else begin
                prev = line(w);
            end
        end
    endtask

    initial monitor(0, int'(BD_A));
    initial monitor(1, int'(BD_B));

    task automatic send_a(input logic [7:0] b);
        wr_a = 1'b1;
        wd_a = b;
        @(negedge clk);
        wr_a = 1'b0;
    endtask

    task automatic wait_idle(input int w, input int limit, output int n);
        n = 0;
        while (((w == 0) ? busy_a : busy_b) && n < limit) begin
            n++;
            @(negedge clk);
        end
        if (n >= limit) chk("idle_timeout", int'((w == 0) ? busy_a : busy_b), 0);
    endtask

    initial begin
        int n;
        int ab0;
        rst = 1'b0;
        wr_a = 1'b0; clr_a = 1'b0; wd_a = 8'h00;
        wr_b = 1'b0; clr_b = 1'b0; wd_b = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx_a), 1);
        chk("rst_count", int'(count_a), 0);
        chk("rst_empty", int'(empty_a), 1);
        chk("rst_full", int'(full_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_ovf", int'(ovf_a), 0);
        chk("rst_tx_b", int'(tx_b), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: latency and frame length
        exp_a.push_back(8'hA5);
        send_a(8'hA5);
        chk("single_count", int'(count_a), 1);
        chk("single_empty", int'(empty_a), 0);
        @(negedge clk);
        chk("single_tx_n1", int'(tx_a), 1);
        chk("single_busy_n1", int'(busy_a), 1);
        chk("single_count_n1", int'(count_a), 0);
        @(negedge clk);
        chk("single_tx_n2", int'(tx_a), 0);
        wait_idle(0, 100, n);
        chk("single_busy_len", n + 1, 40);
        chk("single_empty_end", int'(empty_a), 1);
        chk("single_tx_end", int'(tx_a), 1);
        repeat (5) @(negedge clk);

        // Burst of five: fills to full without a drop, frames contiguous
        starts_a.delete();
        for (int i = 1; i <= 5; i++) exp_a.push_back(8'(i));
        for (int i = 1; i <= 5; i++) send_a(8'(i));
        chk("burst_count", int'(count_a), 4);
        chk("burst_full", int'(full_a), 1);
        chk("burst_ovf", int'(ovf_a), 0);
        wait_idle(0, 400, n);
        repeat (3) @(negedge clk);
        chk("burst_frames", starts_a.size(), 5);
        for (int i = 1; i < starts_a.size(); i++)
            chk($sformatf("burst_gap%0d", i), starts_a[i] - starts_a[i - 1], 40);

        // Overflow, clear, and set-beats-clear
        exp_a.push_back(8'h11);
        for (int i = 0; i < 4; i++) exp_a.push_back(8'(8'h21 + i));
        send_a(8'h11);
        for (int i = 0; i < 4; i++) send_a(8'(8'h21 + i));
        chk("ovf_pre", int'(ovf_a), 0);
        send_a(8'h77);
        chk("ovf_set", int'(ovf_a), 1);
        chk("ovf_count", int'(count_a), 4);
        chk("ovf_full", int'(full_a), 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("ovf_clr", int'(ovf_a), 0);
        clr_a = 1'b1;
        send_a(8'h78);
        clr_a = 1'b0;
        chk("ovf_set_wins", int'(ovf_a), 1);
        chk("ovf_count2", int'(count_a), 4);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        wait_idle(0, 400, n);
        repeat (3) @(negedge clk);
        chk("ovf_final", int'(ovf_a), 0);

        // Reset during data bit 3 of 0xFF
        ab0 = aborted;
        exp_a.push_back(8'hFF);
        send_a(8'hFF);
        repeat (19) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_tx", int'(tx_a), 1);
        chk("mid_rst_count", int'(count_a), 0);
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_empty", int'(empty_a), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        chk("mid_rst_aborted", aborted - ab0, 1);
        chk("mid_rst_pending", exp_a.size(), 0);
        chk("mid_rst_idle", int'(busy_a), 0);

        // Default divider: 0x55 at 434 clk per bit
        exp_b.push_back(8'h55);
        wr_b = 1'b1;
        wd_b = 8'h55;
        @(negedge clk);
        wr_b = 1'b0;
        @(negedge clk);
        chk("def_busy", int'(busy_b), 1);
        wait_idle(1, 5000, n);
        chk("def_frame_len", n, 4340);
        repeat (5) @(negedge clk);
        chk("def_tx_idle", int'(tx_b), 1);

        chk("end_pending_a", exp_a.size(), 0);
        chk("end_pending_b", exp_b.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
